// File: rtl/dct_pkg.sv
// dct_pkg: shared constants for the 8-point 1-D DCT-II datapath.
//   COEF_F_DEF / OUT_W_DEF : default fractional bits and output width.
//   K_W                    : width of one signed cosine coefficient.
//   K                      : 8x8 coefficient table,
//                            K[k][n] = round(2^12 * 0.5 * c(k) * cos((2n+1)k*pi/16)),
//                            c(0) = 1/sqrt(2), c(k>0) = 1. Built for COEF_F = 12.
//   saturate()             : clamp a signed value into a w-bit signed range.
package dct_pkg;

    localparam int COEF_F_DEF = 12;
    localparam int OUT_W_DEF  = 12;
    localparam int K_W        = COEF_F_DEF + 2;

    localparam logic signed [K_W-1:0] K [8][8] = '{
        '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
        '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400,  -14'sd400,  -14'sd1138, -14'sd1703, -14'sd2009},
        '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892, -14'sd1892, -14'sd784,   14'sd784,   14'sd1892},
        '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138,  14'sd1138,  14'sd2009,  14'sd400,  -14'sd1703},
        '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448,  14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
        '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703, -14'sd1703, -14'sd400,   14'sd2009, -14'sd1138},
        '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784,  -14'sd784,   14'sd1892, -14'sd1892,  14'sd784},
        '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009,  14'sd2009, -14'sd1703,  14'sd1138, -14'sd400}
    };

    // Clamp v into [-2^(w-1), 2^(w-1)-1]. The caller detects a clamp event
    // by comparing the result with the input.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/dct_1d_row_mac_lane.sv
// dct_mac_lane: one DCT output lane (coefficient index K_IDX).
//   Stage 3: four registered products op[n] * K[K_IDX][n].
//   Stage 4: sum, round (+2^(COEF_F-1)), arithmetic shift by COEF_F,
//            saturate to OUT_W, register.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_op_valid        i_op holds a valid operand set (loads the products)
//   i_prod_valid      the product registers are valid (loads the output)
//   i_op[4]           butterfly sums (even K_IDX) or differences (odd K_IDX)
//   o_coef            registered, saturated coefficient
//   o_sat             registered clamp flag for o_coef
module dct_mac_lane
    import dct_pkg::*;
#(
    parameter int K_IDX  = 0,
    parameter int OP_W   = 14,
    parameter int COEF_F = COEF_F_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_op_valid,
    input  logic                    i_prod_valid,
    input  logic signed [OP_W-1:0]  i_op [4],
    output logic signed [OUT_W-1:0] o_coef,
    output logic                    o_sat
);

    localparam int PROD_W = OP_W + K_W;
    // Two guard bits above the product width make the 4-term sum exact.
    localparam int ACC_W  = PROD_W + 2;
    localparam logic signed [ACC_W-1:0] RND =
        {{(ACC_W - COEF_F){1'b0}}, 1'b1, {(COEF_F - 1){1'b0}}};

    logic signed [PROD_W-1:0] prod_q [4];
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  shr_d;
    logic signed [63:0]       clamp_d;
    logic                     sat_d;
    logic signed [OUT_W-1:0]  coef_q;
    logic                     sat_q;

    always_comb begin
        acc_d = RND;
        for (int n = 0; n < 4; n++) begin
            acc_d = acc_d + ACC_W'(prod_q[n]);
        end
        shr_d   = acc_d >>> COEF_F;
        clamp_d = saturate(64'(shr_d), OUT_W);
        sat_d   = (clamp_d != 64'(shr_d));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < 4; n++) begin
                prod_q[n] <= '0;
            end
            coef_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (i_op_valid) begin
                for (int n = 0; n < 4; n++) begin
                    prod_q[n] <= PROD_W'(i_op[n]) * PROD_W'(K[K_IDX][n]);
                end
            end
            if (i_prod_valid) begin
                coef_q <= clamp_d[OUT_W-1:0];
                sat_q  <= sat_d;
            end
        end
    end

    assign o_coef = coef_q;
    assign o_sat  = sat_q;

endmodule

// File: rtl/dct_1d_row.sv
// dct_1d_row: pipelined 8-point forward DCT-II, one row per cycle.
//   Stage 1: register inputs with optional level shift (-128 on low 8 bits).
//   Stage 2: even/odd butterflies s[n] = x[n]+x[7-n], d[n] = x[n]-x[7-n].
//   Stages 3-4: eight dct_mac_lane instances (products, round, saturate).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid             i_data0..7 hold a valid row this cycle
//   i_data0..i_data7    samples x[0]..x[7]
//   o_data0..o_data7    signed coefficients y[0]..y[7]
//   o_valid             o_data0..7 valid this cycle
//   o_last              8th output row of a block (qualified by o_valid)
//   o_sat               some lane clamped this row (qualified by o_valid)
//
// Handshake: valid-only streaming, no ready. A row with i_valid=1 in cycle t
// emerges with o_valid=1 in cycle t+4; i_valid=0 cycles travel as bubbles so
// output spacing equals input spacing. Data registers hold when their stage
// is idle, so o_data keeps its last value while o_valid=0.
module dct_1d_row
    import dct_pkg::*;
#(
    parameter int IN_W        = 12,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int COEF_F      = COEF_F_DEF,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [IN_W-1:0]         i_data0,
    input  logic [IN_W-1:0]         i_data1,
    input  logic [IN_W-1:0]         i_data2,
    input  logic [IN_W-1:0]         i_data3,
    input  logic [IN_W-1:0]         i_data4,
    input  logic [IN_W-1:0]         i_data5,
    input  logic [IN_W-1:0]         i_data6,
    input  logic [IN_W-1:0]         i_data7,
    output logic signed [OUT_W-1:0] o_data0,
    output logic signed [OUT_W-1:0] o_data1,
    output logic signed [OUT_W-1:0] o_data2,
    output logic signed [OUT_W-1:0] o_data3,
    output logic signed [OUT_W-1:0] o_data4,
    output logic signed [OUT_W-1:0] o_data5,
    output logic signed [OUT_W-1:0] o_data6,
    output logic signed [OUT_W-1:0] o_data7,
    output logic                    o_valid,
    output logic                    o_last,
    output logic                    o_sat
);

    // One extra bit holds either the level-shifted pixel or a signed sample;
    // one more bit covers the butterfly sum/difference.
    localparam int XW  = IN_W + 1;
    localparam int OPW = IN_W + 2;

    logic [IN_W-1:0]         din [8];
    logic signed [XW-1:0]    x_d [8];
    logic signed [XW-1:0]    x_q [8];
    logic signed [OPW-1:0]   s_q [4];
    logic signed [OPW-1:0]   d_q [4];
    logic                    v1_q, v2_q, v3_q;
    logic                    valid_q, last_q;
    logic [2:0]              cnt_q;
    logic signed [OUT_W-1:0] coef [8];
    logic [7:0]              lane_sat;

    assign din[0] = i_data0;
    assign din[1] = i_data1;
    assign din[2] = i_data2;
    assign din[3] = i_data3;
    assign din[4] = i_data4;
    assign din[5] = i_data5;
    assign din[6] = i_data6;
    assign din[7] = i_data7;

    // Pixel pass ignores the upper input bits.
    if (LEVEL_SHIFT != 0 && IN_W > 8) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{din[0][IN_W-1:8], din[1][IN_W-1:8], din[2][IN_W-1:8],
                             din[3][IN_W-1:8], din[4][IN_W-1:8], din[5][IN_W-1:8],
                             din[6][IN_W-1:8], din[7][IN_W-1:8]};
    end

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            if (LEVEL_SHIFT != 0) begin
                x_d[n] = XW'($signed({1'b0, din[n][7:0]})) - XW'(128);
            end else begin
                x_d[n] = XW'($signed(din[n]));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= 3'd0;
            for (int n = 0; n < 8; n++) begin
                x_q[n] <= '0;
            end
            for (int n = 0; n < 4; n++) begin
                s_q[n] <= '0;
                d_q[n] <= '0;
            end
        end else begin
            v1_q    <= i_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            valid_q <= v3_q;
            // The counter tracks rows about to leave stage 4, so o_last
            // lines up with o_valid and gaps never disturb the count.
            last_q  <= v3_q && (cnt_q == 3'd7);
            if (v3_q) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (i_valid) begin
                for (int n = 0; n < 8; n++) begin
                    x_q[n] <= x_d[n];
                end
            end
            if (v1_q) begin
                for (int n = 0; n < 4; n++) begin
                    s_q[n] <= OPW'(x_q[n]) + OPW'(x_q[7-n]);
                    d_q[n] <= OPW'(x_q[n]) - OPW'(x_q[7-n]);
                end
            end
        end
    end

    // Even coefficient rows are symmetric and use s; odd rows are
    // antisymmetric and use d.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        logic signed [OPW-1:0] op [4];
        for (genvar n = 0; n < 4; n++) begin : g_op
            assign op[n] = (k % 2 == 0) ? s_q[n] : d_q[n];
        end
        dct_mac_lane #(
            .K_IDX  (k),
            .OP_W   (OPW),
            .COEF_F (COEF_F),
            .OUT_W  (OUT_W)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_op_valid   (v2_q),
            .i_prod_valid (v3_q),
            .i_op         (op),
            .o_coef       (coef[k]),
            .o_sat        (lane_sat[k])
        );
    end

    assign o_data0 = coef[0];
    assign o_data1 = coef[1];
    assign o_data2 = coef[2];
    assign o_data3 = coef[3];
    assign o_data4 = coef[4];
    assign o_data5 = coef[5];
    assign o_data6 = coef[6];
    assign o_data7 = coef[7];
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_sat   = |lane_sat;

endmodule
